// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
// Frame-stepped motion controller for a player sprite: walking, jumping,
// rope climbing, gravity, playfield clamping and a timed death/respawn.
// Position and speed are 32-bit signed fixed point with FP_SHIFT fraction bits.
// Nothing changes except on cycles where startOfFrame is high.

module sprite_motion_ctrl #(
  parameter int INITIAL_X      = 280,
  parameter int INITIAL_Y      = 185,
  parameter int FP_SHIFT       = 6,
  parameter int GRAVITY        = 10,
  parameter int JUMP_SPEED     = 300,
  parameter int CLIMB_SPEED    = 100,
  parameter int WALK_SPEED     = 200,
  parameter int MAX_FALL_SPEED = 230,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 570,
  parameter int Y_MAX          = 423,
  parameter int DEATH_FRAMES   = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               leftPressed,
  input  logic               rightPressed,
  input  logic               upPressed,
  input  logic               downPressed,
  input  logic               onFloor,
  input  logic               onRope,
  input  logic               ceilingHit,
  input  logic               wallHitLeft,
  input  logic               wallHitRight,
  input  logic               killHit,
  input  logic signed [15:0] addedSpeed,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [1:0]         state,
  output logic               dead
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    AIR    = 2'd1,
    CLIMB  = 2'd2,
    DEAD   = 2'd3
  } motionStateT;

  localparam logic signed [31:0] INIT_X_FP = 32'(INITIAL_X <<< FP_SHIFT);
  localparam logic signed [31:0] INIT_Y_FP = 32'(INITIAL_Y <<< FP_SHIFT);
  localparam logic signed [31:0] X_MIN_FP  = 32'(X_MIN <<< FP_SHIFT);
  localparam logic signed [31:0] X_MAX_FP  = 32'(X_MAX <<< FP_SHIFT);
  localparam logic signed [31:0] Y_MAX_FP  = 32'(Y_MAX <<< FP_SHIFT);
  localparam logic [15:0]        DEATH_CNT = 16'(DEATH_FRAMES);

  motionStateT        curState;
  logic signed [31:0] posX;
  logic signed [31:0] posY;
  logic signed [31:0] speedX;
  logic signed [31:0] speedY;
  logic [15:0]        deathCnt;
  logic               upPrev;

  logic               upEdge;
  logic               rightOnly;
  logic               leftOnly;
  logic signed [31:0] walkSpeedX;
  logic signed [31:0] sumX;
  logic signed [31:0] sumY;
  logic signed [31:0] pixX;
  logic signed [31:0] pixY;
  logic signed [31:0] clampedPosX;
  logic signed [31:0] clampedPosY;
  logic signed [31:0] clampedPixX;
  logic signed [31:0] limitedSpeedX;
  logic signed [31:0] fallSum;
  logic signed [31:0] cappedFall;

  // Jump/climb-up triggers only on the frame the key goes down.
  assign upEdge    = upPressed & ~upPrev;

  // Horizontal intent: a single unblocked direction walks, anything else
  // lets the sprite ride whatever it stands on.
  assign rightOnly = rightPressed & ~leftPressed;
  assign leftOnly  = leftPressed & ~rightPressed;

  // Requested X speed before the playfield edge check.
  always_comb begin
    if (rightOnly && !wallHitRight) begin
      walkSpeedX = 32'(WALK_SPEED);
    end else if (leftOnly && !wallHitLeft) begin
      walkSpeedX = -32'(WALK_SPEED);
    end else begin
      walkSpeedX = {{16{addedSpeed[15]}}, addedSpeed};
    end
  end

  // Integrate the speed held from the previous frame.
  assign sumX = posX + speedX;
  assign sumY = posY + speedY;
  assign pixX = sumX >>> FP_SHIFT;
  assign pixY = sumY >>> FP_SHIFT;

  // Pixel clamp; a clamped coordinate lands exactly on the edge pixel.
  always_comb begin
    if (pixX > X_MAX) begin
      clampedPosX = X_MAX_FP;
    end else if (pixX < X_MIN) begin
      clampedPosX = X_MIN_FP;
    end else begin
      clampedPosX = sumX;
    end
    if (pixY > Y_MAX) begin
      clampedPosY = Y_MAX_FP;
    end else begin
      clampedPosY = sumY;
    end
  end

  assign clampedPixX = clampedPosX >>> FP_SHIFT;

  // Sitting on an X edge cancels any speed that pushes further into it,
  // so a held key does not make the sprite jitter against the border.
  always_comb begin
    limitedSpeedX = walkSpeedX;
    if (clampedPixX >= X_MAX && walkSpeedX > 0) begin
      limitedSpeedX = '0;
    end else if (clampedPixX <= X_MIN && walkSpeedX < 0) begin
      limitedSpeedX = '0;
    end
  end

  // Gravity with terminal velocity.
  assign fallSum    = speedY + GRAVITY;
  assign cappedFall = (fallSum > MAX_FALL_SPEED) ? 32'(MAX_FALL_SPEED) : fallSum;

  // Motion FSM: kill beats the death timer, which beats normal movement.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      curState <= AIR;
      dead     <= 1'b0;
      posX     <= INIT_X_FP;
      posY     <= INIT_Y_FP;
      speedX   <= '0;
      speedY   <= '0;
      deathCnt <= '0;
      upPrev   <= 1'b0;
    end else if (startOfFrame) begin
      upPrev <= upPressed;
      if (curState != DEAD && killHit) begin
        // Freeze where the hit happened and start the respawn timer.
        curState <= DEAD;
        dead     <= 1'b1;
        speedX   <= '0;
        speedY   <= '0;
        deathCnt <= DEATH_CNT;
      end else if (curState == DEAD) begin
        if (deathCnt <= 16'd1) begin
          curState <= AIR;
          dead     <= 1'b0;
          posX     <= INIT_X_FP;
          posY     <= INIT_Y_FP;
          speedX   <= '0;
          speedY   <= '0;
          deathCnt <= '0;
        end else begin
          deathCnt <= deathCnt - 16'd1;
        end
      end else begin
        posX   <= clampedPosX;
        posY   <= clampedPosY;
        speedX <= limitedSpeedX;
        case (curState)
          GROUND: begin
            if (upEdge && onRope) begin
              curState <= CLIMB;
              speedY   <= -32'(CLIMB_SPEED);
            end else if (upEdge) begin
              curState <= AIR;
              speedY   <= -32'(JUMP_SPEED);
            end else if (downPressed && onRope) begin
              curState <= CLIMB;
              speedY   <= 32'(CLIMB_SPEED);
            end else if (!onFloor) begin
              curState <= AIR;
              speedY   <= '0;
            end else begin
              speedY <= '0;
            end
          end
          CLIMB: begin
            if (!onRope) begin
              curState <= AIR;
              speedY   <= '0;
            end else if (upPressed && !downPressed) begin
              speedY <= -32'(CLIMB_SPEED);
            end else if (downPressed && !upPressed) begin
              speedY <= 32'(CLIMB_SPEED);
            end else begin
              speedY <= '0;
            end
          end
          default: begin
            // AIR: a rope catches the sprite before the floor does.
            if (onRope) begin
              curState <= CLIMB;
              speedY   <= '0;
            end else if (onFloor && !speedY[31]) begin
              curState <= GROUND;
              speedY   <= '0;
            end else if (ceilingHit && speedY[31]) begin
              speedY <= '0;
            end else begin
              speedY <= cappedFall;
            end
          end
        endcase
      end
    end
  end

  assign topLeftX = 11'(posX >>> FP_SHIFT);
  assign topLeftY = 11'(posY >>> FP_SHIFT);
  assign state    = curState;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Testbench for sprite_motion_ctrl: directed scenarios plus randomized
// frames, all compared against a plain-integer model of the motion rules.

module tb_sprite_motion_ctrl;

  localparam int SCALE = 64;
  localparam int S_GROUND = 0;
  localparam int S_AIR = 1;
  localparam int S_CLIMB = 2;
  localparam int S_DEAD = 3;

  logic clk = 1'b0;
  logic resetN;
  logic startOfFrame;
  logic leftPressed, rightPressed, upPressed, downPressed;
  logic onFloor, onRope, ceilingHit, wallHitLeft, wallHitRight, killHit;
  logic signed [15:0] addedSpeed;
  logic signed [10:0] topLeftX, topLeftY;
  logic [1:0] state;
  logic dead;

  int checks = 0;
  int errors = 0;
  int frameNo = 0;

  // Reference model: pixels * 64 fixed point kept as plain integers.
  int mState, mPx, mPy, mVx, mVy, mCnt;
  bit mUpPrev;

  sprite_motion_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .leftPressed(leftPressed), .rightPressed(rightPressed),
    .upPressed(upPressed), .downPressed(downPressed),
    .onFloor(onFloor), .onRope(onRope), .ceilingHit(ceilingHit),
    .wallHitLeft(wallHitLeft), .wallHitRight(wallHitRight),
    .killHit(killHit), .addedSpeed(addedSpeed),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .state(state), .dead(dead)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic signed [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floorDiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic modelReset();
    mState = S_AIR; mPx = 280 * SCALE; mPy = 185 * SCALE;
    mVx = 0; mVy = 0; mCnt = 0; mUpPrev = 0;
  endtask

  // One frame of the game rules, applied to the currently driven inputs.
  task automatic modelFrame();
    bit edgeUp;
    int newVx, newVy, px, py;
    edgeUp = upPressed && !mUpPrev;
    mUpPrev = upPressed;
    if (mState != S_DEAD && killHit) begin
      mState = S_DEAD; mVx = 0; mVy = 0; mCnt = 60;
      return;
    end
    if (mState == S_DEAD) begin
      if (mCnt == 1) begin
        mState = S_AIR; mPx = 280 * SCALE; mPy = 185 * SCALE;
        mVx = 0; mVy = 0; mCnt = 0;
      end else begin
        mCnt = mCnt - 1;
      end
      return;
    end
    if (rightPressed && !leftPressed && !wallHitRight) newVx = 200;
    else if (leftPressed && !rightPressed && !wallHitLeft) newVx = -200;
    else newVx = int'(addedSpeed);
    newVy = mVy;
    if (mState == S_GROUND) begin
      if (edgeUp && onRope) begin mState = S_CLIMB; newVy = -100; end
      else if (edgeUp) begin mState = S_AIR; newVy = -300; end
      else if (downPressed && onRope) begin mState = S_CLIMB; newVy = 100; end
      else if (!onFloor) begin mState = S_AIR; newVy = 0; end
      else newVy = 0;
    end else if (mState == S_CLIMB) begin
      if (!onRope) begin mState = S_AIR; newVy = 0; end
      else if (upPressed && !downPressed) newVy = -100;
      else if (downPressed && !upPressed) newVy = 100;
      else newVy = 0;
    end else begin
      if (onRope) begin mState = S_CLIMB; newVy = 0; end
      else if (onFloor && mVy >= 0) begin mState = S_GROUND; newVy = 0; end
      else if (ceilingHit && mVy < 0) newVy = 0;
      else newVy = (mVy + 10 > 230) ? 230 : mVy + 10;
    end
    mPx = mPx + mVx;
    mPy = mPy + mVy;
    px = floorDiv(mPx, SCALE);
    if (px > 570) mPx = 570 * SCALE;
    else if (px < 0) mPx = 0;
    px = floorDiv(mPx, SCALE);
    if (px >= 570 && newVx > 0) newVx = 0;
    if (px <= 0 && newVx < 0) newVx = 0;
    py = floorDiv(mPy, SCALE);
    if (py > 423) mPy = 423 * SCALE;
    mVx = newVx;
    mVy = newVy;
  endtask

  task automatic compareAll(input string tag);
    checkVal({tag, ".x"}, 32'(topLeftX), floorDiv(mPx, SCALE));
    checkVal({tag, ".y"}, 32'(topLeftY), floorDiv(mPy, SCALE));
    checkVal({tag, ".state"}, {30'd0, state}, mState);
    checkVal({tag, ".dead"}, {31'd0, dead}, (mState == S_DEAD) ? 1 : 0);
  endtask

  task automatic clearInputs();
    leftPressed = 0; rightPressed = 0; upPressed = 0; downPressed = 0;
    onFloor = 0; onRope = 0; ceilingHit = 0; wallHitLeft = 0;
    wallHitRight = 0; killHit = 0; addedSpeed = '0; startOfFrame = 0;
  endtask

  // Drive startOfFrame for 'cycles' consecutive clocks, then compare.
  task automatic runFrame(input string tag, input int cycles);
    @(negedge clk);
    startOfFrame = 1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      modelFrame();
    end
    #1;
    startOfFrame = 0;
    frameNo++;
    $display("frame %0d %s x=%0d y=%0d state=%0d dead=%0d", frameNo, tag,
             topLeftX, topLeftY, state, dead);
    compareAll(tag);
  endtask

  // Idle clocks with scrambled inputs must not move anything.
  task automatic idleCycles(input int n);
    @(negedge clk);
    leftPressed = 1'($urandom); rightPressed = 1'($urandom);
    upPressed = 1'($urandom); onFloor = 1'($urandom); killHit = 1'($urandom);
    addedSpeed = 16'($urandom);
    repeat (n) @(posedge clk);
    #1;
    $display("idle %0d cycles x=%0d y=%0d state=%0d", n, topLeftX, topLeftY, state);
    compareAll("idle");
  endtask

  // Asynchronous reset: outputs must show spawn values without a clock edge.
  task automatic applyReset(input string tag);
    @(negedge clk);
    #2;
    resetN = 0;
    #1;
    modelReset();
    $display("reset %s x=%0d y=%0d state=%0d dead=%0d", tag, topLeftX, topLeftY, state, dead);
    checkVal({tag, ".rstX"}, 32'(topLeftX), 280);
    checkVal({tag, ".rstY"}, 32'(topLeftY), 185);
    checkVal({tag, ".rstState"}, {30'd0, state}, S_AIR);
    checkVal({tag, ".rstDead"}, {31'd0, dead}, 0);
    clearInputs();
    @(negedge clk);
    resetN = 1;
  endtask

  initial begin
    int prevX;
    clearInputs();
    resetN = 1;
    modelReset();

    // Power-up reset.
    applyReset("boot");

    // Free fall from spawn: speed ramps 10..100, Y ends at 185 + 450/64.
    for (int i = 0; i < 10; i++) runFrame("fall", 1);
    checkVal("fall.finalY", 32'(topLeftY), 192);

    // Land, then a held up key gives exactly one jump.
    onFloor = 1;
    runFrame("land", 1);
    checkVal("land.state", {30'd0, state}, S_GROUND);
    upPressed = 1;
    runFrame("jump", 1);
    checkVal("jump.state", {30'd0, state}, S_AIR);
    onFloor = 0;
    for (int i = 0; i < 4; i++) runFrame("jumpHeld", 1);
    ceilingHit = 1;
    runFrame("ceiling", 1);
    ceilingHit = 0;
    onFloor = 1;
    runFrame("reland", 1);
    runFrame("reland", 1);
    runFrame("noRejump", 1);
    checkVal("noRejump.state", {30'd0, state}, S_GROUND);
    upPressed = 0;

    // Walking into a wall: carrier speed of 64 moves one pixel per frame.
    rightPressed = 1; wallHitRight = 1; addedSpeed = 16'sd64;
    runFrame("carry", 1);
    prevX = int'(topLeftX);
    runFrame("carry", 1);
    checkVal("carry.dx", 32'(topLeftX) - prevX, 1);
    prevX = int'(topLeftX);
    runFrame("carry", 1);
    checkVal("carry.dx", 32'(topLeftX) - prevX, 1);

    // Walk right from x=568 into the right border.
    applyReset("edge");
    onFloor = 1; addedSpeed = 16'sd18432;
    runFrame("toEdge", 1);
    addedSpeed = 16'sd0;
    runFrame("toEdge", 1);
    checkVal("edge.start", 32'(topLeftX), 568);
    rightPressed = 1;
    for (int i = 0; i < 4; i++) runFrame("edgeWalk", 1);
    checkVal("edge.clamp", 32'(topLeftX), 570);

    // Death in the air: frozen for 60 frames, then respawn in AIR.
    applyReset("kill");
    runFrame("preKill", 1);
    runFrame("preKill", 1);
    killHit = 1;
    runFrame("kill", 1);
    checkVal("kill.dead", {31'd0, dead}, 1);
    for (int i = 0; i < 59; i++) begin
      killHit = 1'($urandom);
      rightPressed = 1'($urandom);
      runFrame("deadWait", 1);
    end
    checkVal("kill.stillDead", {31'd0, dead}, 1);
    killHit = 0;
    runFrame("respawn", 1);
    checkVal("respawn.x", 32'(topLeftX), 280);
    checkVal("respawn.y", 32'(topLeftY), 185);
    checkVal("respawn.state", {30'd0, state}, S_AIR);

    // Reset in the middle of the death timer.
    clearInputs();
    killHit = 1;
    runFrame("kill2", 1);
    killHit = 0;
    for (int i = 0; i < 10; i++) runFrame("deadWait2", 1);
    applyReset("midDead");
    runFrame("afterReset", 1);

    // Randomized play.
    for (int i = 0; i < 400; i++) begin
      leftPressed  = ($urandom_range(0, 3) == 0);
      rightPressed = ($urandom_range(0, 2) == 0);
      upPressed    = ($urandom_range(0, 3) == 0);
      downPressed  = ($urandom_range(0, 3) == 0);
      onFloor      = ($urandom_range(0, 2) != 0);
      onRope       = ($urandom_range(0, 4) == 0);
      ceilingHit   = ($urandom_range(0, 5) == 0);
      wallHitLeft  = ($urandom_range(0, 5) == 0);
      wallHitRight = ($urandom_range(0, 5) == 0);
      killHit      = ($urandom_range(0, 59) == 0);
      addedSpeed   = 16'($signed($urandom_range(0, 600)) - 300);
      runFrame("rand", ($urandom_range(0, 9) == 0) ? 2 : 1);
      if ($urandom_range(0, 7) == 0) idleCycles($urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): INITIAL_X 280 spawn X px; INITIAL_Y 185 spawn Y px; FP_SHIFT 6 fixed-point fraction bits; GRAVITY 10 Y speed increment/frame; JUMP_SPEED 300; CLIMB_SPEED 100; WALK_SPEED 200; MAX_FALL_SPEED 230; X_MIN 0; X_MAX 570; Y_MAX 423 px clamp; DEATH_FRAMES 60.
REQ-002 clk  in  1  system clock.
REQ-003 resetN  in  1  asynchronous, active-low reset.
REQ-004 startOfFrame  in  1  one-clk pulse per frame; all state/position updates occur only on it.
REQ-005 leftPressed, rightPressed, upPressed, downPressed  in  1 each  keyboard levels.
REQ-006 onFloor, onRope  in  1 each  footing/rope overlap flags.
REQ-007 ceilingHit, wallHitLeft, wallHitRight  in  1 each  blocking collision flags.
REQ-008 killHit  in  1  lethal collision.
REQ-009 addedSpeed  in  16 signed  carrier (rope/platform) X speed, fixed-point units/frame.
REQ-010 topLeftX, topLeftY  out  11 signed  pixel position.
REQ-011 state  out  2  0=GROUND 1=AIR 2=CLIMB 3=DEAD.
REQ-012 dead  out  1  high iff state==DEAD.

Function
REQ-013 Position SHALL be held as 32-bit signed fixed point; topLeftX/Y = posFP >>> FP_SHIFT (arithmetic, floor).
REQ-014 Speeds SHALL be 32-bit signed, positive Y = downward; inputs sampled on the startOfFrame cycle; no change on other cycles.
REQ-015 upEdge = upPressed & !upPrev; upPrev SHALL update only on startOfFrame.
REQ-016 Priority per frame: killHit > DEAD handling > state transitions > motion.
REQ-017 killHit in non-DEAD state: state->DEAD, Xspeed=Yspeed=0, counter=DEATH_FRAMES, position held that frame; killHit while DEAD SHALL be ignored.
REQ-018 DEAD: position frozen; counter decrements per frame; on the frame counter==1, position->INITIAL, state->AIR, speeds 0, counter->0.
REQ-019 Xspeed (non-DEAD): right only and !wallHitRight -> +WALK_SPEED; left only and !wallHitLeft -> -WALK_SPEED; otherwise (none, both, or blocked) -> addedSpeed.
REQ-020 GROUND: upEdge & onRope -> CLIMB, Yspeed=-CLIMB_SPEED; upEdge & !onRope -> AIR, Yspeed=-JUMP_SPEED; downPressed & onRope -> CLIMB, Yspeed=+CLIMB_SPEED; !onFloor -> AIR, Yspeed=0; else Yspeed=0.
REQ-021 CLIMB: !onRope -> AIR, Yspeed=0; up -> -CLIMB_SPEED; down -> +CLIMB_SPEED; both/neither -> 0.
REQ-022 AIR: onRope -> CLIMB, Yspeed=0; onFloor & Yspeed>=0 -> GROUND, Yspeed=0; ceilingHit & Yspeed<0 -> Yspeed=0; else Yspeed=min(Yspeed+GRAVITY, MAX_FALL_SPEED).
REQ-023 Position SHALL integrate the speed held before this frame's update (one-frame latency): posFP += speed.
REQ-024 After integration, X pixel SHALL clamp to [X_MIN, X_MAX] and Y to <= Y_MAX (fraction zeroed on clamp); Xspeed toward a clamped edge SHALL be zeroed.
REQ-025 startOfFrame held high multiple cycles SHALL update once per cycle high (no internal edge detect).

Reset
REQ-026 On resetN low, immediately: posFP=INITIAL<<FP_SHIFT, speeds 0, state=AIR, counter 0, upPrev=0; outputs topLeftX=280, topLeftY=185, dead=0.
REQ-027 Reset mid-DEAD or mid-jump SHALL abort fully to REQ-026 values; first frame after release follows AIR rules.

Verification
REQ-028 Reset, onFloor=0, 10 frames -> Yspeed 10,20..100; topLeftY=185+floor(450/64)=192.
REQ-029 GROUND, upPressed held 5 frames -> single jump, Yspeed -300 then -290..; no re-jump while held.
REQ-030 GROUND, rightPressed, wallHitRight=1, addedSpeed=64 -> Xspeed 64, X +1 px/frame.
REQ-031 Walk right from X=568 -> clamps at 570, Xspeed 0.
REQ-032 killHit in AIR -> dead=1, 60 frames frozen, then X=280, Y=185, state AIR.
REQ-033 resetN low during DEAD -> immediate spawn values, dead=0.
